memory_cycle: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, the data-memory access FSM with a req/ack handshake, load/store lane formatting and the MEM/WB pipeline register.
- Drives StallM to the hazard unit while a data-memory access is outstanding.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/lsu_format.sv | 65 ++++++
 rtl/memory_cycle.sv | 214 +++++++++++++++++++++
 tb/tb_memory_cycle.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: funct3 codes, memory-stage FSM states, stage register layouts.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//
// Contents:
//   XLEN            datapath width (32 only)
//   F3_L*/F3_S*     load/store funct3 encodings
//   mem_state_t     data-memory access FSM states (MS_IDLE, MS_WAIT, MS_ERR)
//   exmem_t         EX/MEM pipeline register contents
//   memwb_t         MEM/WB pipeline register contents
//   is_misaligned   alignment rule for a memory op given funct3 and addr[1:0]
package riscv_pkg;

    localparam int XLEN = 32;

    // Loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_ERR  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            mem_write;
        logic            mem_read;
        logic            mem_to_reg;
        logic            reg_write;
    } exmem_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_to_reg;
        logic            misalign;
        logic            bus_err;
    } memwb_t;

    // Size code 11 (a doubleword on RV64) has no RV32 meaning, so it is
    // always reported as misaligned rather than silently issued.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_format.sv
// Load/store lane formatting: store byte-lane replication + byte enables, load lane extraction + extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   funct3      load/store width and sign
//   addr_lo     byte offset within the word (addr[1:0])
//   is_store    1 = store formatting, 0 = read (all byte enables set)
//   store_data  rs2 value to be stored
//   rdata       raw word returned by memory
//   wdata       lane-replicated store data
//   be          byte enables
//   load_data   extracted and extended load result
module lsu_format
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic            is_store,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] lane;

    // Sub-word stores replicate the datum across every lane so the memory
    // only has to honour the byte enables, not shift the data.
    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << addr_lo;
                end
                F3_SH: begin
                    wdata = {2{store_data[15:0]}};
                    be    = 4'b0011 << addr_lo;
                end
                default: begin
                    wdata = store_data;
                    be    = 4'b1111;
                end
            endcase
        end
    end

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  load_data = {24'd0, lane[7:0]};
            F3_LHU:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// RISC-V memory stage: EX/MEM register, data-memory req/ack FSM with timeout, lane formatting, MEM/WB register.
// Latency: zero-wait access completes in 1 cycle; an ack on request cycle N adds N-1 stall cycles.
// Backpressure: StallM holds the front of the pipe while a request is outstanding; MEM/WB takes bubbles meanwhile.
//
// Ports:
//   clk, rst_n                 pipeline clock, synchronous active-low reset
//   *E                         execute-stage outputs captured into EX/MEM
//   StallM                     freezes PC, IF/ID, ID/EX and EX/MEM
//   dmem_req/we/addr/wdata/be  data-memory request, held stable until ack
//   dmem_rdata, dmem_ack       read data and one-cycle completion pulse
//   *W                         MEM/WB register outputs (MisalignW / BusErrW flag killed ops)
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,  // request cycles allowed before a bus error (>= 1)
    parameter int XLEN    = 32   // only 32 is supported
)(
    input  logic            clk,
    input  logic            rst_n,

    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [4:0]      RdE,
    input  logic [2:0]      Funct3E,
    input  logic            MemWriteE,
    input  logic            MemReadE,
    input  logic            MemToRegE,
    input  logic            RegWriteE,

    output logic            StallM,

    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,

    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic            MemToRegW,
    output logic            MisalignW,
    output logic            BusErrW
);

    // The counter only has to reach TIMEOUT-1.
    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    exmem_t          m_d, m_q;
    memwb_t          w_d, w_q;
    mem_state_t      state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;

    logic            memop_raw;
    logic            misalign;
    logic            memop;
    logic            req;
    logic            stall;
    logic            complete;
    logic            bus_err;
    logic [XLEN-1:0] fmt_wdata;
    logic [XLEN-1:0] fmt_load;
    logic [3:0]      fmt_be;

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_comb begin
        m_d            = '0;
        m_d.alu_result = ALUResultE;
        m_d.write_data = WriteDataE;
        m_d.rd         = RdE;
        m_d.funct3     = Funct3E;
        m_d.mem_write  = MemWriteE;
        m_d.mem_read   = MemReadE;
        m_d.mem_to_reg = MemToRegE;
        m_d.reg_write  = RegWriteE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q <= '0;
        end else if (!stall) begin
            m_q <= m_d;
        end
    end

    // ------------------------------------------------------------------
    // Alignment: a misaligned op never reaches the bus
    // ------------------------------------------------------------------
    assign memop_raw = m_q.mem_read | m_q.mem_write;
    assign misalign  = memop_raw & is_misaligned(m_q.funct3, m_q.alu_result[1:0]);
    assign memop     = memop_raw & ~misalign;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The IDLE request cycle counts as the first of the TIMEOUT cycles, so
    // WAIT gives up once it has spent TIMEOUT-1 cycles of its own.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        bus_err  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (memop) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = '0;
                        state_d = (TIMEOUT == 1) ? MS_ERR : MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    complete = 1'b1;
                    state_d  = MS_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == LAST) begin
                        state_d = MS_ERR;
                    end
                end
            end
            MS_ERR: begin
                // The timed-out op retires this cycle as a killed instruction.
                bus_err = 1'b1;
                cnt_d   = '0;
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lane formatting
    // ------------------------------------------------------------------
    lsu_format u_lsu_format (
        .funct3     (m_q.funct3),
        .addr_lo    (m_q.alu_result[1:0]),
        .is_store   (m_q.mem_write),
        .store_data (m_q.write_data),
        .rdata      (dmem_rdata),
        .wdata      (fmt_wdata),
        .be         (fmt_be),
        .load_data  (fmt_load)
    );

    // EX/MEM is frozen while waiting, so addr/we/be/wdata stay stable.
    assign dmem_req   = req;
    assign dmem_we    = req & m_q.mem_write;
    assign dmem_addr  = {m_q.alu_result[XLEN-1:2], 2'b00};
    assign dmem_wdata = fmt_wdata;
    assign dmem_be    = fmt_be;
    assign StallM     = stall;

    // ------------------------------------------------------------------
    // MEM/WB register: a stalled cycle retires an all-zero bubble
    // ------------------------------------------------------------------
    always_comb begin
        w_d = '0;
        if (!stall) begin
            w_d.alu_result = m_q.alu_result;
            w_d.rd         = m_q.rd;
            w_d.mem_to_reg = m_q.mem_to_reg;
            w_d.misalign   = misalign;
            w_d.bus_err    = bus_err;
            w_d.reg_write  = m_q.reg_write & ~misalign & ~bus_err;
            w_d.read_data  = (m_q.mem_read & complete) ? fmt_load : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    assign ALUResultW = w_q.alu_result;
    assign ReadDataW  = w_q.read_data;
    assign RdW        = w_q.rd;
    assign RegWriteW  = w_q.reg_write;
    assign MemToRegW  = w_q.mem_to_reg;
    assign MisalignW  = w_q.misalign;
    assign BusErrW    = w_q.bus_err;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed vector table, reset-in-WAIT sequence, random ops vs a reference model.
// Latency: n/a (bench).
// Backpressure: the bench plays the data memory and returns ack on a chosen request cycle (0 = never).
module tb_memory_cycle;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResultE, WriteDataE;
    logic [4:0]  RdE;
    logic [2:0]  Funct3E;
    logic        MemWriteE, MemReadE, MemToRegE, RegWriteE;
    logic        StallM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] ALUResultW, ReadDataW;
    logic [4:0]  RdW;
    logic        RegWriteW, MemToRegW, MisalignW, BusErrW;

    always #5 clk = ~clk;

    memory_cycle #(.TIMEOUT(TO), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .Funct3E(Funct3E),
        .MemWriteE(MemWriteE), .MemReadE(MemReadE), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
        .StallM(StallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemToRegW(MemToRegW), .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    typedef struct {
        logic [31:0] alu, wd, rdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mw, mr, mtr, rw;
        int          lat;
        logic [31:0] e_alu, e_read, e_addr, e_wd;
        logic [4:0]  e_rd;
        logic [3:0]  e_be;
        logic        e_rw, e_mtr, e_mis, e_ber, e_req;
        int          e_stalls;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t row(
        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd,
        input logic [2:0] f3, input logic mw, input logic mr, input logic mtr, input logic rw, input int lat,
        input logic [31:0] e_alu, input logic [4:0] e_rd, input logic e_rw, input logic e_mtr,
        input logic [31:0] e_read, input logic e_mis, input logic e_ber, input int e_stalls, input logic e_req,
        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
        vec_t v;
        v.alu = alu; v.wd = wd; v.rdata = rdata; v.rd = rd; v.f3 = f3;
        v.mw = mw; v.mr = mr; v.mtr = mtr; v.rw = rw; v.lat = lat;
        v.e_alu = e_alu; v.e_rd = e_rd; v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_read = e_read;
        v.e_mis = e_mis; v.e_ber = e_ber; v.e_stalls = e_stalls; v.e_req = e_req;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd;
        return v;
    endfunction

    // Reference model: derives the expected outcome from access size,
    // byte offset and ack latency using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   e;
        int     off;
        int     sz;
        bit     memop;
        bit     mis;
        longint val;
        e     = v;
        off   = int'(v.alu % 4);
        sz    = (v.f3 % 4 == 0) ? 1 : (v.f3 % 4 == 1) ? 2 : (v.f3 % 4 == 2) ? 4 : 8;
        memop = v.mr || v.mw;
        mis   = memop && (sz == 8 || (off % sz) != 0);
        e.e_alu = v.alu; e.e_rd = v.rd; e.e_mtr = v.mtr; e.e_rw = v.rw;
        e.e_read = 0; e.e_mis = 0; e.e_ber = 0; e.e_req = 0; e.e_stalls = 0;
        e.e_addr = v.alu - 32'(off);
        e.e_be   = 4'hF;
        e.e_wd   = v.wd;
        if (v.mw && sz == 1) begin e.e_be = 4'(1 << off); e.e_wd = (v.wd % 256) * 32'h01010101; end
        if (v.mw && sz == 2) begin e.e_be = 4'(3 << off); e.e_wd = (v.wd % 65536) * 32'h00010001; end
        if (memop && mis) begin
            e.e_mis = 1; e.e_rw = 0;
        end else if (memop) begin
            e.e_req = 1;
            if (v.lat >= 1 && v.lat <= TO) begin
                e.e_stalls = v.lat - 1;
                if (v.mr) begin
                    val = longint'(v.rdata) >> (8 * off);
                    val = val % (longint'(1) << (8 * sz));
                    if (v.f3 < 4 && sz < 4 && val >= (longint'(1) << (8 * sz - 1)))
                        val = val - (longint'(1) << (8 * sz));
                    e.e_read = 32'(val);
                end
            end else begin
                e.e_stalls = TO; e.e_ber = 1; e.e_rw = 0;
            end
        end
        return e;
    endfunction

    task automatic drive_e(input vec_t v);
        ALUResultE = v.alu; WriteDataE = v.wd; RdE = v.rd; Funct3E = v.f3;
        MemWriteE = v.mw; MemReadE = v.mr; MemToRegE = v.mtr; RegWriteE = v.rw;
    endtask

    task automatic drive_nop();
        ALUResultE = '0; WriteDataE = '0; RdE = '0; Funct3E = '0;
        MemWriteE = 1'b0; MemReadE = 1'b0; MemToRegE = 1'b0; RegWriteE = 1'b0;
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, ".ALUResultW"}, ALUResultW, 32'h0);
        check({tag, ".ReadDataW"}, ReadDataW, 32'h0);
        check({tag, ".RdW"}, 32'(RdW), 32'h0);
        check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'h0);
        check({tag, ".MemToRegW"}, 32'(MemToRegW), 32'h0);
        check({tag, ".MisalignW"}, 32'(MisalignW), 32'h0);
        check({tag, ".BusErrW"}, 32'(BusErrW), 32'h0);
    endtask

    // Entered and left just after a rising edge; a NOP follows the op.
    task automatic apply(input vec_t v, input string tag);
        int stalls = 0;
        bit reqseen = 0;
        bit prev_stall = 0;
        bit done = 0;
        bit stall_now;
        drive_e(v);
        @(posedge clk); #1;
        drive_nop();
        for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
            dmem_rdata = v.rdata;
            dmem_ack   = dmem_req && (cyc == v.lat);
            #1;
            if (prev_stall) begin
                check({tag, ".bubble_RegWriteW"}, 32'(RegWriteW), 32'h0);
                check({tag, ".bubble_RdW"}, 32'(RdW), 32'h0);
            end
            if (dmem_req && v.e_req) begin
                check({tag, ".dmem_addr"}, dmem_addr, v.e_addr);
                check({tag, ".dmem_be"}, 32'(dmem_be), 32'(v.e_be));
                check({tag, ".dmem_we"}, 32'(dmem_we), 32'(v.mw));
                if (v.mw) check({tag, ".dmem_wdata"}, dmem_wdata, v.e_wd);
            end
            if (dmem_req) reqseen = 1;
            stall_now = StallM;
            if (stall_now) stalls++;
            prev_stall = stall_now;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!stall_now) done = 1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL %s.stall_bound: StallM still high after 64 cycles, required release", tag);
        end
        check({tag, ".stalls"}, 32'(stalls), 32'(v.e_stalls));
        check({tag, ".req_seen"}, 32'(reqseen), 32'(v.e_req));
        check({tag, ".ALUResultW"}, ALUResultW, v.e_alu);
        check({tag, ".RdW"}, 32'(RdW), 32'(v.e_rd));
        check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(v.e_rw));
        check({tag, ".MemToRegW"}, 32'(MemToRegW), 32'(v.e_mtr));
        check({tag, ".ReadDataW"}, ReadDataW, v.e_read);
        check({tag, ".MisalignW"}, 32'(MisalignW), 32'(v.e_mis));
        check({tag, ".BusErrW"}, 32'(BusErrW), 32'(v.e_ber));
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        r;
        int          kind;
        logic [2:0]  lf3 [6];
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

        rst_n = 1'b0; drive_nop(); dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.StallM", 32'(StallM), 32'h0);
        check("reset.dmem_req", 32'(dmem_req), 32'h0);
        check_w_zero("reset");
        rst_n = 1'b1;

        //            alu           wd            rdata         rd  f3      mw mr mtr rw lat  e_alu         e_rd e_rw e_mtr e_read        mis ber stl req e_addr        e_be     e_wd
        tbl.push_back(row(32'h1234,     32'h0,        32'h0,        5,  3'b000, 0, 0, 0, 1, 1,   32'h1234,     5,   1,   0,    32'h0,        0,  0,  0,  0,  32'h0,        4'hF,    32'h0));
        tbl.push_back(row(32'h103,      32'hAB,       32'h0,        0,  3'b000, 1, 0, 0, 0, 3,   32'h103,      0,   0,   0,    32'h0,        0,  0,  2,  1,  32'h100,      4'b1000, 32'hABABABAB));
        tbl.push_back(row(32'h102,      32'h0,        32'h00800000, 7,  3'b000, 0, 1, 1, 1, 1,   32'h102,      7,   1,   1,    32'hFFFFFF80, 0,  0,  0,  1,  32'h100,      4'hF,    32'h0));
        tbl.push_back(row(32'h102,      32'h0,        32'h00800000, 7,  3'b100, 0, 1, 1, 1, 1,   32'h102,      7,   1,   1,    32'h00000080, 0,  0,  0,  1,  32'h100,      4'hF,    32'h0));
        tbl.push_back(row(32'h101,      32'h0,        32'h0,        8,  3'b001, 0, 1, 1, 1, 1,   32'h101,      8,   0,   1,    32'h0,        1,  0,  0,  0,  32'h0,        4'hF,    32'h0));
        tbl.push_back(row(32'h200,      32'h0,        32'hDEADBEEF, 9,  3'b010, 0, 1, 1, 1, 0,   32'h200,      9,   0,   1,    32'h0,        0,  1,  4,  1,  32'h200,      4'hF,    32'h0));
        tbl.push_back(row(32'h102,      32'h1234CDEF, 32'h0,        0,  3'b001, 1, 0, 0, 0, 2,   32'h102,      0,   0,   0,    32'h0,        0,  0,  1,  1,  32'h100,      4'b1100, 32'hCDEFCDEF));
        tbl.push_back(row(32'h102,      32'h0,        32'h80017F00, 10, 3'b001, 0, 1, 1, 1, 1,   32'h102,      10,  1,   1,    32'hFFFF8001, 0,  0,  0,  1,  32'h100,      4'hF,    32'h0));
        tbl.push_back(row(32'h102,      32'h0,        32'h80017F00, 10, 3'b101, 0, 1, 1, 1, 1,   32'h102,      10,  1,   1,    32'h00008001, 0,  0,  0,  1,  32'h100,      4'hF,    32'h0));
        tbl.push_back(row(32'h104,      32'h11223344, 32'h0,        0,  3'b010, 1, 0, 0, 0, 4,   32'h104,      0,   0,   0,    32'h0,        0,  0,  3,  1,  32'h104,      4'hF,    32'h11223344));
        tbl.push_back(row(32'h102,      32'h0,        32'h0,        3,  3'b010, 0, 1, 1, 1, 1,   32'h102,      3,   0,   1,    32'h0,        1,  0,  0,  0,  32'h0,        4'hF,    32'h0));
        tbl.push_back(row(32'h100,      32'h0,        32'h0,        4,  3'b011, 0, 1, 1, 1, 1,   32'h100,      4,   0,   1,    32'h0,        1,  0,  0,  0,  32'h0,        4'hF,    32'h0));
        tbl.push_back(row(32'h101,      32'h0,        32'h00007F00, 0,  3'b000, 0, 1, 1, 1, 1,   32'h101,      0,   1,   1,    32'h0000007F, 0,  0,  0,  1,  32'h100,      4'hF,    32'h0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while an LW is waiting for an ack that arrives too late.
        drive_e(row(32'h300, 32'h0, 32'h0, 9, 3'b010, 0, 1, 1, 1, 0,
                    32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        @(posedge clk); #1;
        drive_nop();
        check("rstwait.req_idle", 32'(dmem_req), 32'h1);
        @(posedge clk); #1;
        check("rstwait.stall_wait", 32'(StallM), 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstwait.req_after", 32'(dmem_req), 32'h0);
        check("rstwait.stall_after", 32'(StallM), 32'h0);
        check_w_zero("rstwait");
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        #1;
        check("rstwait.late_ack_req", 32'(dmem_req), 32'h0);
        check("rstwait.late_ack_stall", 32'(StallM), 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("rstwait.after_ack_req", 32'(dmem_req), 32'h0);
        check_w_zero("rstwait_ack");

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            kind    = int'($urandom_range(0, 2));
            r       = tbl[0];
            r.alu   = $urandom;
            r.wd    = $urandom;
            r.rdata = $urandom;
            r.rd    = 5'($urandom);
            r.mw = 1'b0; r.mr = 1'b0; r.mtr = 1'b0; r.rw = 1'b0;
            r.lat   = int'($urandom_range(0, TO + 1));
            if ($urandom_range(0, 1) == 1) r.alu[1:0] = 2'b00;
            case (kind)
                0: begin r.rw = 1'b1; r.f3 = 3'($urandom_range(0, 7)); end
                1: begin r.mr = 1'b1; r.mtr = 1'b1; r.rw = 1'b1; r.f3 = lf3[$urandom_range(0, 5)]; end
                default: begin r.mw = 1'b1; r.f3 = 3'($urandom_range(0, 3)); end
            endcase
            apply(model(r), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
